if_id_skid_reg: RTL
===================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the instruction and incremented-PC paths.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fullInstruction  input  DATA_W  instruction word from the fetch stage.
REQ-005 SHALL have port incrPC  input  DATA_W  PC+4 accompanying fullInstruction.
REQ-006 SHALL have port if_valid  input  1  fetch stage presents a valid word.
REQ-007 SHALL have port if_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port flush  input  1  discard all held and incoming words (taken branch/jump).
REQ-009 SHALL have port id_instruction  output  DATA_W  instruction presented to decode.
REQ-010 SHALL have port id_incrPC  output  DATA_W  PC+4 presented to decode.
REQ-011 SHALL have port id_valid  output  1  id_instruction/id_incrPC are valid.
REQ-012 SHALL have port id_ready  input  1  decode consumes the presented word this cycle.
REQ-013 SHALL have port bubble_count  output  16  count of decode idle cycles.

Function
REQ-014 SHALL define in_fire = if_valid & if_ready and out_fire = id_valid & id_ready.
REQ-015 SHALL hold a main register (drives id_* outputs) and one skid register, each with data and valid bit.
REQ-016 SHALL implement states EMPTY (no valid entry), ONE (main valid), FULL (main and skid valid).
REQ-017 SHALL drive if_ready = NOT skid valid, from registered state only; no combinational path from id_ready to if_ready.
REQ-018 EMPTY: in_fire -> load main, go ONE; else stay EMPTY.
REQ-019 ONE: in_fire & out_fire -> load main with new word, stay ONE; in_fire only -> load skid, go FULL; out_fire only -> go EMPTY.
REQ-020 FULL: out_fire -> move skid into main, go ONE; else hold both, stay FULL (if_ready = 0, so no in_fire possible).
REQ-021 SHALL present words to decode in exactly the accepted order, with no loss and no duplication.
REQ-022 SHALL have one-cycle latency: word accepted at edge N in EMPTY appears with id_valid=1 after edge N.
REQ-023 flush SHALL take priority over all transfers: next state EMPTY, both valid bits cleared, word offered that cycle discarded, main and skid data cleared to 0x00000000 (MIPS nop).
REQ-024 flush with out_fire in the same cycle SHALL still count the word as consumed by decode; no replay.
REQ-025 Data registers SHALL change only on load or flush; held values SHALL be stable while id_valid=1 and id_ready=0.
REQ-026 bubble_count SHALL increment by 1 each cycle where id_ready=1 and id_valid=0, saturate at 0xFFFF, and be unaffected by flush.

Reset
REQ-027 reset_n=0 SHALL immediately (asynchronously) force state EMPTY, id_valid=0, if_ready=1, id_instruction=0, id_incrPC=0, bubble_count=0.
REQ-028 Deassertion of reset_n SHALL be the only prerequisite for accepting data; first in_fire may occur on the first rising edge after deassertion.

Verification
REQ-029 Stream: id_ready=1, if_valid=1, words 0x20080001,0x20090002,0x01095020 with incrPC 4,8,12 -> same words on id_* one cycle later in order, if_ready constantly 1, bubble_count unchanged after first word.
REQ-030 Backpressure: words A,B,C offered continuously, id_ready=0 for 3 cycles -> id_instruction holds A, skid holds B, if_ready=0, C held upstream; id_ready=1 -> A,B,C delivered on consecutive cycles, no loss/duplication.
REQ-031 Flush in FULL with if_valid=1 -> next cycle id_valid=0, if_ready=1, id_instruction=0x00000000, offered word never appears.
REQ-032 Reset mid-operation in FULL: reset_n=0 between edges -> id_valid=0, if_ready=1, outputs 0 before next edge; after release, first accepted word delivered normally.
REQ-033 Idle: id_ready=1, if_valid=0 for 5 cycles after reset -> bubble_count=5; preload 0xFFFE plus 3 idle cycles -> bubble_count=0xFFFF held.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
//   IF/ID pipeline register with a one-entry skid buffer. Fetch and decode
//   talk through a valid/ready handshake. Decode reads the main register.
//   The skid register catches the one word that may arrive while decode is
//   stalled, so if_ready can come from registered state alone. This keeps
//   the long id_ready -> if_ready combinational path out of the fetch stage.
//
// Ports
//   clock           rising-edge clock for all state
//   reset_n         asynchronous, active-low reset
//   fullInstruction instruction word from fetch
//   incrPC          PC+4 accompanying fullInstruction
//   if_valid        fetch presents a valid word
//   if_ready        block accepts a word this cycle (registered)
//   flush           discard held and incoming words (taken branch/jump)
//   id_instruction  instruction presented to decode
//   id_incrPC       PC+4 presented to decode
//   id_valid        id_instruction/id_incrPC are valid
//   id_ready        decode consumes the presented word this cycle
//   bubble_count    saturating count of cycles decode wanted a word and had none
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] fullInstruction,
   input  logic [DATA_W-1:0] incrPC,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] id_instruction,
   output logic [DATA_W-1:0] id_incrPC,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [15:0]       bubble_count
);

   // The state encodes both valid bits: main valid = ONE|FULL, skid valid = FULL
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]        stateReg;
   logic [DATA_W-1:0] mainInstrReg;
   logic [DATA_W-1:0] mainPcReg;
   logic [DATA_W-1:0] skidInstrReg;
   logic [DATA_W-1:0] skidPcReg;
   logic [15:0]       bubbleCountReg;

   logic inFire;
   logic outFire;

   // if_ready depends only on stateReg, never on id_ready
   assign if_ready       = (stateReg != FULL);
   assign id_valid       = (stateReg != EMPTY);
   assign id_instruction = mainInstrReg;
   assign id_incrPC      = mainPcReg;
   assign bubble_count   = bubbleCountReg;

   assign inFire  = if_valid & if_ready;
   assign outFire = id_valid & id_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stateReg       <= EMPTY;
         mainInstrReg   <= '0;
         mainPcReg      <= '0;
         skidInstrReg   <= '0;
         skidPcReg      <= '0;
         bubbleCountReg <= '0;
      end else begin
         // Decode idle cycles are counted whether or not a flush happens
         if (id_ready && !id_valid && (bubbleCountReg != 16'hFFFF))
            bubbleCountReg <= bubbleCountReg + 16'd1;

         if (flush) begin
            // Clearing the data registers leaves a nop (all zeros) on the decode inputs
            stateReg     <= EMPTY;
            mainInstrReg <= '0;
            mainPcReg    <= '0;
            skidInstrReg <= '0;
            skidPcReg    <= '0;
         end else begin
            case (stateReg)
               EMPTY: begin
                  if (inFire) begin
                     mainInstrReg <= fullInstruction;
                     mainPcReg    <= incrPC;
                     stateReg     <= ONE;
                  end
               end
               ONE: begin
                  if (inFire && outFire) begin
                     mainInstrReg <= fullInstruction;
                     mainPcReg    <= incrPC;
                  end else if (inFire) begin
                     // Decode stalled: hold main and park the new word in the skid
                     skidInstrReg <= fullInstruction;
                     skidPcReg    <= incrPC;
                     stateReg     <= FULL;
                  end else if (outFire) begin
                     stateReg <= EMPTY;
                  end
               end
               FULL: begin
                  // if_ready is low here, so only the drain of the skid can happen
                  if (outFire) begin
                     mainInstrReg <= skidInstrReg;
                     mainPcReg    <= skidPcReg;
                     stateReg     <= ONE;
                  end
               end
               default: stateReg <= EMPTY;
            endcase
         end
      end
   end

endmodule
